// File: rtl/reqrsp_to_axi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reqrsp_to_axi_bridge                                       |
// | Description : Bridges a single-beat request/response master port onto    |
// |               an AXI4+ATOP master port. One transaction in flight, so    |
// |               responses return strictly in request order.                |
// | Option      : REQRSP_TO_AXI_ATOP_EN - when defined, Swap..Minu atomics   |
// |               are issued as AXI ATOPs; when undefined they are answered  |
// |               locally with p_error=1, p_data=0 and aw_atop is tied to 0. |
// | Ports       : clk_i/rst_i  clock, synchronous active-high reset          |
// |               q_*          request channel (addr/write/amo/data/strb/    |
// |                            size, valid/ready)                            |
// |               p_*          response channel (data/error, valid/ready)    |
// |               axi_*        AXI4+ATOP master (AW, W, B, AR, R)            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module reqrsp_to_axi_bridge #(
    parameter int AXI_ID_WIDTH   = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_USER_WIDTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_WIDTH-1:0]     q_addr,
    input  logic                      q_write,
    input  logic [3:0]                q_amo,
    input  logic [DATA_WIDTH-1:0]     q_data,
    input  logic [DATA_WIDTH/8-1:0]   q_strb,
    input  logic [2:0]                q_size,
    input  logic                      q_valid,
    output logic                      q_ready,
    output logic [DATA_WIDTH-1:0]     p_data,
    output logic                      p_error,
    output logic                      p_valid,
    input  logic                      p_ready,
    output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
    output logic [ADDR_WIDTH-1:0]     axi_aw_addr,
    output logic [7:0]                axi_aw_len,
    output logic [2:0]                axi_aw_size,
    output logic [1:0]                axi_aw_burst,
    output logic                      axi_aw_lock,
    output logic [3:0]                axi_aw_cache,
    output logic [2:0]                axi_aw_prot,
    output logic [3:0]                axi_aw_qos,
    output logic [3:0]                axi_aw_region,
    output logic [5:0]                axi_aw_atop,
    output logic [AXI_USER_WIDTH-1:0] axi_aw_user,
    output logic                      axi_aw_valid,
    input  logic                      axi_aw_ready,
    output logic [DATA_WIDTH-1:0]     axi_w_data,
    output logic [DATA_WIDTH/8-1:0]   axi_w_strb,
    output logic                      axi_w_last,
    output logic [AXI_USER_WIDTH-1:0] axi_w_user,
    output logic                      axi_w_valid,
    input  logic                      axi_w_ready,
    input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
    input  logic [1:0]                axi_b_resp,
    input  logic [AXI_USER_WIDTH-1:0] axi_b_user,
    input  logic                      axi_b_valid,
    output logic                      axi_b_ready,
    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
    output logic [ADDR_WIDTH-1:0]     axi_ar_addr,
    output logic [7:0]                axi_ar_len,
    output logic [2:0]                axi_ar_size,
    output logic [1:0]                axi_ar_burst,
    output logic                      axi_ar_lock,
    output logic [3:0]                axi_ar_cache,
    output logic [2:0]                axi_ar_prot,
    output logic [3:0]                axi_ar_qos,
    output logic [3:0]                axi_ar_region,
    output logic [AXI_USER_WIDTH-1:0] axi_ar_user,
    output logic                      axi_ar_valid,
    input  logic                      axi_ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
    input  logic [DATA_WIDTH-1:0]     axi_r_data,
    input  logic [1:0]                axi_r_resp,
    input  logic                      axi_r_last,
    input  logic [AXI_USER_WIDTH-1:0] axi_r_user,
    input  logic                      axi_r_valid,
    output logic                      axi_r_ready
);

    localparam logic [3:0] c_AMO_AND     = 4'd3;
    localparam logic [3:0] c_AMO_LR      = 4'd10;
    localparam logic [3:0] c_AMO_SC      = 4'd11;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;

`ifdef REQRSP_TO_AXI_ATOP_EN
    localparam bit c_ATOP_EN = 1'b1;
`else
    localparam bit c_ATOP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [3:0]              r_amo;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_strb;
    logic [2:0]              r_size;
    logic                    r_atop;
    logic                    r_ar_done, r_aw_done, r_w_done, r_b_done, r_r_done;
    logic [DATA_WIDTH-1:0]   r_p_data;
    logic                    r_p_error;

    logic w_q_is_atop, w_q_issue_atop, w_q_reject, w_q_hs;
    logic w_b_seen, w_r_seen;
    logic w_unused;

    assign w_q_is_atop    = (q_amo >= 4'd1) && (q_amo <= 4'd9);
    assign w_q_issue_atop = c_ATOP_EN && w_q_is_atop;
    // Atomics that cannot be forwarded are answered locally with an error.
    assign w_q_reject     = !c_ATOP_EN && w_q_is_atop;
    assign w_q_hs         = q_valid && q_ready;

    // Completion of a write: B plus, for an ATOP, the R beat, in either order.
    assign w_b_seen = r_b_done || axi_b_valid;
    assign w_r_seen = !r_atop || r_r_done || axi_r_valid;

    assign w_unused = ^{axi_b_id, axi_b_user, axi_r_id, axi_r_last, axi_r_user, axi_r_resp[0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_r_done  <= 1'b0;
            r_atop    <= 1'b0;
            r_p_data  <= '0;
            r_p_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_q_hs) begin
                        r_addr    <= q_addr;
                        r_amo     <= q_amo;
                        r_size    <= q_size;
                        r_strb    <= q_strb;
                        // AXI atomic CLR clears the set bits, so AND sends the complement.
                        r_wdata   <= (q_amo == c_AMO_AND) ? ~q_data : q_data;
                        r_atop    <= w_q_issue_atop;
                        r_ar_done <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_b_done  <= 1'b0;
                        r_r_done  <= 1'b0;
                        r_p_data  <= '0;
                        r_p_error <= w_q_reject;
                    end
                end
                ST_RD: begin
                    if (axi_ar_valid && axi_ar_ready) r_ar_done <= 1'b1;
                    if (axi_r_valid && axi_r_ready) begin
                        r_p_data  <= axi_r_data;
                        r_p_error <= axi_r_resp[1];
                    end
                end
                ST_WR: begin
                    if (axi_aw_valid && axi_aw_ready) r_aw_done <= 1'b1;
                    if (axi_w_valid && axi_w_ready)   r_w_done  <= 1'b1;
                    if (axi_b_valid && axi_b_ready && !r_b_done) begin
                        r_b_done  <= 1'b1;
                        r_p_error <= axi_b_resp[1];
                        // SC reports success as 0, failure as 1.
                        if (r_amo == c_AMO_SC)
                            r_p_data <= (axi_b_resp == c_RESP_EXOKAY) ? '0 : DATA_WIDTH'(1);
                    end
                    if (axi_r_valid && axi_r_ready && !r_r_done) begin
                        r_r_done <= 1'b1;
                        r_p_data <= axi_r_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        q_ready      = 1'b0;
        p_valid      = 1'b0;
        axi_aw_valid = 1'b0;
        axi_w_valid  = 1'b0;
        axi_b_ready  = 1'b0;
        axi_ar_valid = 1'b0;
        axi_r_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                q_ready = 1'b1;
                if (q_valid)
                    w_state_nxt = w_q_reject ? ST_RSP : (q_write ? ST_WR : ST_RD);
            end
            ST_RD: begin
                axi_ar_valid = !r_ar_done;
                axi_r_ready  = r_ar_done;
                if (r_ar_done && axi_r_valid) w_state_nxt = ST_RSP;
            end
            ST_WR: begin
                axi_aw_valid = !r_aw_done;
                axi_w_valid  = !r_w_done;
                axi_b_ready  = 1'b1;
                axi_r_ready  = r_atop;
                if (w_b_seen && w_r_seen) w_state_nxt = ST_RSP;
            end
            ST_RSP: begin
                p_valid = 1'b1;
                if (p_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // No handshake signal may be active while reset is asserted.
        if (rst_i) begin
            q_ready      = 1'b0;
            p_valid      = 1'b0;
            axi_aw_valid = 1'b0;
            axi_w_valid  = 1'b0;
            axi_b_ready  = 1'b0;
            axi_ar_valid = 1'b0;
            axi_r_ready  = 1'b0;
        end
    end

    assign p_data  = p_valid ? r_p_data : '0;
    assign p_error = p_valid && r_p_error;

    assign axi_aw_id     = '0;
    assign axi_aw_addr   = r_addr;
    assign axi_aw_len    = 8'd0;
    assign axi_aw_size   = r_size;
    assign axi_aw_burst  = c_BURST_INCR;
    assign axi_aw_lock   = (r_amo == c_AMO_SC);
    assign axi_aw_cache  = 4'd0;
    assign axi_aw_prot   = 3'd0;
    assign axi_aw_qos    = 4'd0;
    assign axi_aw_region = 4'd0;
    assign axi_aw_user   = '0;

`ifdef REQRSP_TO_AXI_ATOP_EN
    always_comb begin
        axi_aw_atop = 6'b000000;
        if (r_atop) begin
            case (r_amo)
                4'd1:    axi_aw_atop = 6'b110000; // Swap
                4'd2:    axi_aw_atop = 6'b100000; // Add
                4'd3:    axi_aw_atop = 6'b100001; // And (CLR)
                4'd4:    axi_aw_atop = 6'b100011; // Or (SET)
                4'd5:    axi_aw_atop = 6'b100010; // Xor (EOR)
                4'd6:    axi_aw_atop = 6'b100100; // Max
                4'd7:    axi_aw_atop = 6'b100110; // Maxu
                4'd8:    axi_aw_atop = 6'b100101; // Min
                4'd9:    axi_aw_atop = 6'b100111; // Minu
                default: axi_aw_atop = 6'b000000;
            endcase
        end
    end
`else
    assign axi_aw_atop = 6'b000000;
`endif

    assign axi_w_data  = r_wdata;
    assign axi_w_strb  = r_strb;
    assign axi_w_last  = 1'b1;
    assign axi_w_user  = '0;

    assign axi_ar_id     = '0;
    assign axi_ar_addr   = r_addr;
    assign axi_ar_len    = 8'd0;
    assign axi_ar_size   = r_size;
    assign axi_ar_burst  = c_BURST_INCR;
    assign axi_ar_lock   = (r_amo == c_AMO_LR);
    assign axi_ar_cache  = 4'd0;
    assign axi_ar_prot   = 3'd0;
    assign axi_ar_qos    = 4'd0;
    assign axi_ar_region = 4'd0;
    assign axi_ar_user   = '0;

endmodule
`default_nettype wire

// File: tb/tb_reqrsp_to_axi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_reqrsp_to_axi_bridge                                    |
// | Description : Self-checking bench for reqrsp_to_axi_bridge: directed     |
// |               read/write/atomic/LR-SC/reset steps plus random traffic    |
// |               against an AXI slave model with random stalls.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_reqrsp_to_axi_bridge;

`ifdef REQRSP_TO_AXI_ATOP_EN
    localparam bit c_ATOP_EN = 1'b1;
`else
    localparam bit c_ATOP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_i;
    logic [31:0] q_addr;
    logic        q_write;
    logic [3:0]  q_amo;
    logic [31:0] q_data;
    logic [3:0]  q_strb;
    logic [2:0]  q_size;
    logic        q_valid, q_ready;
    logic [31:0] p_data;
    logic        p_error, p_valid, p_ready;
    logic [1:0]  axi_aw_id, axi_aw_user, axi_w_user, axi_b_id, axi_b_user;
    logic [1:0]  axi_ar_id, axi_ar_user, axi_r_id, axi_r_user;
    logic [31:0] axi_aw_addr, axi_ar_addr, axi_w_data, axi_r_data;
    logic [7:0]  axi_aw_len, axi_ar_len;
    logic [2:0]  axi_aw_size, axi_ar_size, axi_aw_prot, axi_ar_prot;
    logic [1:0]  axi_aw_burst, axi_ar_burst, axi_b_resp, axi_r_resp;
    logic        axi_aw_lock, axi_ar_lock;
    logic [3:0]  axi_aw_cache, axi_ar_cache, axi_aw_qos, axi_ar_qos;
    logic [3:0]  axi_aw_region, axi_ar_region, axi_w_strb;
    logic [5:0]  axi_aw_atop;
    logic        axi_aw_valid, axi_aw_ready, axi_w_last, axi_w_valid, axi_w_ready;
    logic        axi_b_valid, axi_b_ready, axi_ar_valid, axi_ar_ready;
    logic        axi_r_last, axi_r_valid, axi_r_ready;

    reqrsp_to_axi_bridge dut (
        .clk_i(clk), .rst_i(rst_i),
        .q_addr(q_addr), .q_write(q_write), .q_amo(q_amo), .q_data(q_data),
        .q_strb(q_strb), .q_size(q_size), .q_valid(q_valid), .q_ready(q_ready),
        .p_data(p_data), .p_error(p_error), .p_valid(p_valid), .p_ready(p_ready),
        .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
        .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst), .axi_aw_lock(axi_aw_lock),
        .axi_aw_cache(axi_aw_cache), .axi_aw_prot(axi_aw_prot), .axi_aw_qos(axi_aw_qos),
        .axi_aw_region(axi_aw_region), .axi_aw_atop(axi_aw_atop), .axi_aw_user(axi_aw_user),
        .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
        .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
        .axi_w_user(axi_w_user), .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
        .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_user(axi_b_user),
        .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
        .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
        .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst), .axi_ar_lock(axi_ar_lock),
        .axi_ar_cache(axi_ar_cache), .axi_ar_prot(axi_ar_prot), .axi_ar_qos(axi_ar_qos),
        .axi_ar_region(axi_ar_region), .axi_ar_user(axi_ar_user),
        .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
        .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
        .axi_r_last(axi_r_last), .axi_r_user(axi_r_user), .axi_r_valid(axi_r_valid),
        .axi_r_ready(axi_r_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        lock;
        logic [5:0]  atop;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    ax_t  exp_ax[$];
    rsp_t exp_rsp[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   run      = 1'b0;
    bit   hold_p   = 1'b0;

    // Slave behaviour knobs: fixed values for directed steps, address-derived otherwise.
    bit          fixed     = 1'b1;
    int          max_stall = 0;
    logic [31:0] fix_rdata = 32'h0;
    logic [1:0]  fix_rresp = 2'b00;
    logic [1:0]  fix_bresp = 2'b00;
    int          fix_rdly  = 0;
    int          fix_bdly  = 0;

    localparam logic [28:0] c_AX_MISC = {8'd0, 2'b01, 2'd0, 4'd0, 3'd0, 4'd0, 4'd0, 2'd0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return fixed ? fix_rdata : ({a[15:0], ~a[15:0]} ^ 32'h1357_9BDF);
    endfunction
    function automatic logic [1:0] rresp_of(input logic [31:0] a);
        return fixed ? fix_rresp : ((a[4] & a[9]) ? 2'b10 : 2'b00);
    endfunction
    function automatic logic [1:0] bresp_of(input logic [31:0] a);
        return fixed ? fix_bresp : ((a[5] & a[10]) ? 2'b10 : (a[6] ? 2'b01 : 2'b00));
    endfunction
    function automatic int stall();
        if (max_stall == 0) return 0;
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, max_stall)) : 0;
    endfunction
    function automatic int rdly();
        return fixed ? fix_rdly : stall();
    endfunction
    function automatic int bdly();
        return fixed ? fix_bdly : stall();
    endfunction
    function automatic logic [5:0] atop_of(input logic [3:0] amo);
        case (amo)
            4'd1: return 6'b110000;
            4'd2: return 6'b100000;
            4'd3: return 6'b100001;
            4'd4: return 6'b100011;
            4'd5: return 6'b100010;
            4'd6: return 6'b100100;
            4'd7: return 6'b100110;
            4'd8: return 6'b100101;
            4'd9: return 6'b100111;
            default: return 6'b000000;
        endcase
    endfunction

    // Builds expectations, then drives the request until accepted.
    task automatic send(input logic wr, input logic [3:0] amo, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [2:0] size);
        ax_t  a;
        rsp_t r;
        int   n;
        logic is_atop;
        logic [1:0] br;
        is_atop = (amo >= 4'd1) && (amo <= 4'd9);
        br      = bresp_of(addr);
        a.wr    = wr;
        a.addr  = addr;
        a.size  = size;
        a.lock  = (amo == 4'd10) || (amo == 4'd11);
        a.atop  = atop_of(amo);
        a.wdata = (amo == 4'd3) ? ~data : data;
        a.strb  = strb;
        if (is_atop && !c_ATOP_EN) begin
            r.data = 32'h0;
            r.err  = 1'b1;
        end else begin
            exp_ax.push_back(a);
            if (!wr) begin
                r.data = rdata_of(addr);
                r.err  = rresp_of(addr) >> 1;
            end else if (amo == 4'd11) begin
                r.data = (br == 2'b01) ? 32'd0 : 32'd1;
                r.err  = br[1];
            end else if (is_atop) begin
                r.data = rdata_of(addr);
                r.err  = br[1];
            end else begin
                r.data = 32'h0;
                r.err  = br[1];
            end
        end
        exp_rsp.push_back(r);
        q_write = wr; q_amo = amo; q_addr = addr; q_data = data; q_strb = strb; q_size = size;
        q_valid = 1'b1;
        n = 0;
        while (!q_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("q_accept_timeout", 64'(n), 64'(0));
        @(negedge clk);
        q_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_ax.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("drain_timeout", 64'(exp_rsp.size()), 64'(0));
    endtask

    // Response consumer with random back-pressure.
    initial begin
        rsp_t e;
        p_ready = 1'b0;
        wait (run);
        forever begin
            @(negedge clk);
            p_ready = hold_p ? 1'b0 : ((max_stall == 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
            if (p_valid && p_ready) begin
                chk("rsp_expected", 64'(exp_rsp.size() != 0), 64'(1));
                if (exp_rsp.size() != 0) begin
                    e = exp_rsp.pop_front();
                    chk("p_data", 64'(p_data), 64'(e.data));
                    chk("p_error", 64'(p_error), 64'(e.err));
                end
            end else if (!p_valid) begin
                chk("p_idle_zero", {31'd0, p_error, p_data}, 64'd0);
            end
        end
    end

    // AXI slave model.
    initial begin
        ax_t cur;
        logic [31:0] pend_rdata;
        logic [1:0]  pend_rresp, pend_bresp;
        int r_cnt = -1, b_cnt = -1, ar_st = 0, aw_st = 0, w_st = 0;
        bit r_hs = 0, b_hs = 0, aw_got = 0, w_got = 0, cur_open = 0;
        logic aw_hs, w_hs;
        cur = '0; pend_rdata = '0; pend_rresp = '0; pend_bresp = '0;
        axi_aw_ready = 0; axi_w_ready = 0; axi_ar_ready = 0;
        axi_b_valid = 0; axi_b_resp = 0; axi_b_id = 0; axi_b_user = 0;
        axi_r_valid = 0; axi_r_data = 0; axi_r_resp = 0; axi_r_last = 0;
        axi_r_id = 0; axi_r_user = 0;
        wait (run);
        forever begin
            @(negedge clk);
            if (r_hs) begin axi_r_valid = 0; axi_r_last = 0; r_hs = 0; end
            if (b_hs) begin axi_b_valid = 0; b_hs = 0; end
            if (r_cnt > 0) r_cnt--;
            else if (r_cnt == 0) begin
                axi_r_valid = 1; axi_r_data = pend_rdata; axi_r_resp = pend_rresp;
                axi_r_last = 1; r_cnt = -1;
            end
            if (b_cnt > 0) b_cnt--;
            else if (b_cnt == 0) begin
                axi_b_valid = 1; axi_b_resp = pend_bresp; b_cnt = -1;
            end
            axi_ar_ready = axi_ar_valid && (ar_st == 0);
            if (axi_ar_valid && ar_st > 0) ar_st--;
            axi_aw_ready = axi_aw_valid && (aw_st == 0);
            if (axi_aw_valid && aw_st > 0) aw_st--;
            axi_w_ready = axi_w_valid && (w_st == 0);
            if (axi_w_valid && w_st > 0) w_st--;

            if (axi_ar_valid && axi_ar_ready) begin
                chk("ar_expected", 64'(exp_ax.size() != 0), 64'(1));
                if (exp_ax.size() != 0) begin
                    cur = exp_ax.pop_front();
                    chk("ar_kind", 64'(cur.wr), 64'(0));
                    chk("ar_addr", 64'(axi_ar_addr), 64'(cur.addr));
                    chk("ar_size", 64'(axi_ar_size), 64'(cur.size));
                    chk("ar_lock", 64'(axi_ar_lock), 64'(cur.lock));
                    chk("ar_misc", 64'({axi_ar_len, axi_ar_burst, axi_ar_id, axi_ar_cache,
                        axi_ar_prot, axi_ar_qos, axi_ar_region, axi_ar_user}), 64'(c_AX_MISC));
                    pend_rdata = rdata_of(cur.addr);
                    pend_rresp = rresp_of(cur.addr);
                    r_cnt = rdly();
                end
                ar_st = stall();
            end
            aw_hs = axi_aw_valid && axi_aw_ready;
            w_hs  = axi_w_valid && axi_w_ready;
            if ((aw_hs || w_hs) && !cur_open) begin
                chk("aw_expected", 64'(exp_ax.size() != 0), 64'(1));
                if (exp_ax.size() != 0) begin
                    cur = exp_ax.pop_front();
                    cur_open = 1;
                    chk("aw_kind", 64'(cur.wr), 64'(1));
                end
            end
            if (aw_hs) begin
                chk("aw_addr", 64'(axi_aw_addr), 64'(cur.addr));
                chk("aw_size", 64'(axi_aw_size), 64'(cur.size));
                chk("aw_lock", 64'(axi_aw_lock), 64'(cur.lock));
                chk("aw_atop", 64'(axi_aw_atop), 64'(cur.atop));
                chk("aw_misc", 64'({axi_aw_len, axi_aw_burst, axi_aw_id, axi_aw_cache,
                    axi_aw_prot, axi_aw_qos, axi_aw_region, axi_aw_user}), 64'(c_AX_MISC));
                aw_got = 1;
                aw_st = stall();
            end
            if (w_hs) begin
                chk("w_data", 64'(axi_w_data), 64'(cur.wdata));
                chk("w_strb_last_user", 64'({axi_w_strb, axi_w_last, axi_w_user}),
                    64'({cur.strb, 1'b1, 2'b00}));
                w_got = 1;
                w_st = stall();
            end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; cur_open = 0;
                pend_bresp = bresp_of(cur.addr);
                b_cnt = bdly();
                if (cur.atop != 6'd0) begin
                    pend_rdata = rdata_of(cur.addr);
                    pend_rresp = rresp_of(cur.addr);
                    r_cnt = rdly();
                end
            end
            if (axi_r_valid && axi_r_ready) r_hs = 1;
            if (axi_b_valid && axi_b_ready) b_hs = 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] amo;
        logic       wr;
        int         n;
        rst_i = 1; q_valid = 0; q_addr = 0; q_write = 0; q_amo = 0;
        q_data = 0; q_strb = 0; q_size = 0;
        repeat (3) @(negedge clk);
        chk("rst_q_ready", 64'(q_ready), 64'(0));
        chk("rst_valids", 64'({p_valid, axi_aw_valid, axi_w_valid, axi_ar_valid,
            axi_b_ready, axi_r_ready}), 64'(0));
        rst_i = 0;
        #1;
        chk("post_rst_q_ready", 64'(q_ready), 64'(1));
        chk("post_rst_p", 64'({p_valid, p_error, p_data}), 64'(0));
        run = 1;

        // Read 0x100, size 2, R = 0xDEADBEEF OKAY.
        fix_rdata = 32'hDEAD_BEEF; fix_rresp = 2'b00;
        send(1'b0, 4'd0, 32'h100, 32'h0, 4'hF, 3'd2);
        drain();
        // Write 0x20, B = SLVERR.
        fix_bresp = 2'b10;
        send(1'b1, 4'd0, 32'h20, 32'h1234_5678, 4'hF, 3'd2);
        drain();
        // AMO And, R arrives well before B.
        fix_rdata = 32'hA5A5_A5A5; fix_bresp = 2'b00; fix_rdly = 0; fix_bdly = 6;
        send(1'b1, 4'd3, 32'h80, 32'h0000_FFFF, 4'hF, 3'd2);
        drain();
        // AMO Minu with B delivered before R.
        fix_rdata = 32'h0000_0042; fix_bresp = 2'b10; fix_rdly = 5; fix_bdly = 0;
        send(1'b1, 4'd9, 32'h84, 32'h0000_0007, 4'hF, 3'd2);
        drain();
        // LR then SC (EXOKAY -> 0), SC again (OKAY -> 1).
        fix_rdata = 32'h1122_3344; fix_rdly = 0; fix_bdly = 0;
        send(1'b0, 4'd10, 32'h40, 32'h0, 4'hF, 3'd2);
        drain();
        fix_bresp = 2'b01;
        send(1'b1, 4'd11, 32'h40, 32'hCAFE_0001, 4'hF, 3'd2);
        drain();
        fix_bresp = 2'b00;
        send(1'b1, 4'd11, 32'h40, 32'hCAFE_0002, 4'hF, 3'd2);
        drain();

        // Random traffic with AXI and response back-pressure.
        fixed = 0; max_stall = 20;
        for (int i = 0; i < 500; i++)
            send(1'b0, 4'd0, 32'($urandom) & 32'hFFFF_FFFC, 32'($urandom),
                 4'hF, 3'($urandom_range(0, 2)));
        drain();
        for (int i = 0; i < 500; i++)
            send(1'b1, 4'd0, 32'($urandom) & 32'hFFFF_FFFC, 32'($urandom),
                 4'($urandom_range(1, 15)), 3'($urandom_range(0, 2)));
        drain();
        for (int i = 0; i < 1000; i++) begin
            amo = 4'($urandom_range(0, 11));
            wr  = (amo == 4'd0) ? 1'($urandom_range(0, 1)) : (amo != 4'd10);
            send(wr, amo, 32'($urandom) & 32'hFFFF_FFFC, 32'($urandom),
                 4'($urandom_range(1, 15)), 3'($urandom_range(0, 2)));
        end
        drain();

        // Reset while the response is held in RSP.
        fixed = 1; max_stall = 0; fix_rdata = 32'h5555_AAAA; fix_rresp = 2'b00;
        fix_rdly = 0; fix_bdly = 0;
        hold_p = 1;
        send(1'b0, 4'd0, 32'h200, 32'h0, 4'hF, 3'd2);
        n = 0;
        while (!p_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_reached", 64'(p_valid), 64'(1));
        @(negedge clk);
        chk("rsp_held_data", 64'({p_valid, p_data}), 64'({1'b1, 32'h5555_AAAA}));
        rst_i = 1;
        @(negedge clk);
        chk("rst_in_rsp_p_valid", 64'(p_valid), 64'(0));
        chk("rst_in_rsp_q_ready", 64'(q_ready), 64'(0));
        rst_i = 0;
        #1;
        chk("after_rst_q_ready", 64'(q_ready), 64'(1));
        chk("after_rst_p_valid", 64'(p_valid), 64'(0));
        exp_rsp.delete();
        hold_p = 0;

        // One more transaction after reset, then confirm everything is quiet.
        @(negedge clk);
        fix_rdata = 32'h0BAD_F00D;
        send(1'b0, 4'd0, 32'h300, 32'h0, 4'hF, 3'd2);
        drain();
        repeat (3) @(negedge clk);
        chk("quiet_axi", 64'({axi_aw_valid, axi_w_valid, axi_ar_valid, axi_b_ready,
            axi_r_ready, p_valid}), 64'(0));
        chk("quiet_q_ready", 64'(q_ready), 64'(1));
        chk("quiet_queues", 64'(exp_ax.size() + exp_rsp.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
